tetris_engine: RTL and testbench
================================

# tetris_engine

Game-logic core of the Tetris design: it holds the 10×23 playfield, the falling piece position, the game-control state machine and completed-line detection and clearing. It sits below the frame/fall-rate dividers, which supply a single-cycle `tick`, and above the display logic, which reads the board through a row port.

## Interface
Parameters
- `SPAWN_X`, default 4: spawn column of the piece centre.
- `SPAWN_Y`, default 20: spawn row of the piece centre.

Ports
- `clock` in 1: system clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `start_game` in 1: level; starts play from IDLE.
- `tick` in 1: one-cycle fall strobe.
- `key_left` in 1: one-cycle move-left request.
- `key_right` in 1: one-cycle move-right request.
- `dbg_we` in 1: board row write, honoured only in IDLE.
- `dbg_row` in 5: row index for `dbg_we`.
- `dbg_data` in 10: row data for `dbg_we`.
- `rd_row` in 5: board read row.
- `rd_data` out 10: combinational `board[rd_row]`; bit j is column j.
- `piece_x` out 4: centre column.
- `piece_y` out 5: centre row.
- `state` out 3: FSM state encoding.
- `game_over` out 1: high in state OVER.
- `lines_cleared` out 8: count of cleared lines, saturating at 255.

## Operation
Board geometry
- Rows 0..22; row 0 is the bottom.
- Rows 0..19 are visible; rows 20..22 are the spawn area.

Piece (fixed T shape; centre (x,y))
- Cells: (x,y), (x-1,y), (x+1,y), (x,y+1).

Collision flags (combinational)
- `filled_under`: any cell has y==0, or the board cell below it is set.
- `filled_left`: any cell has x==0, or the board cell left of it is set.
- `filled_right`: any cell has x==9, or the board cell right of it is set.
- `completed`[19:0]: bit k = AND of `board[k]`.
- `clr_idx`: lowest set bit of `completed`.

FSM states (encoding 0..5)
- IDLE: accepts `dbg_we` writes. Goes to LOAD when `start_game`=1.
- LOAD: (x,y) ← (SPAWN_X, SPAWN_Y). Goes to OVER if any spawn cell is occupied; otherwise goes to DROP.
- DROP, evaluated each cycle in this priority order:
  - `tick` && `filled_under` → LOCK.
  - `tick` → y−1.
  - `key_left` && !`filled_left` → x−1.
  - `key_right` && !`filled_right` → x+1.
  - Otherwise hold.
- LOCK: sets the four cells in the board, then goes to CHECK.
- CHECK:
  - If `completed`≠0: shifts rows `clr_idx`..21 down by one (row k ← row k+1), clears row 22, increments `lines_cleared`, and stays in CHECK.
  - If `completed`=0: goes to OVER if any row 20..22 is nonzero; otherwise goes to LOAD.
- OVER: holds until reset.

Boundary rules
- Keys outside DROP are ignored. A key blocked by a wall or an occupied cell is ignored.
- Simultaneous left and right: left wins.
- `tick` wins over keys in the same cycle.

## Timing
Reset values
- Board all zero, state IDLE.
- x=SPAWN_X, y=SPAWN_Y.
- `game_over`=0, `lines_cleared`=0.

Latencies
- `start_game` → LOAD: one cycle.
- LOAD → DROP: one cycle.
- Moves are visible on `piece_x`/`piece_y` one cycle after the request.
- Each line clear takes one CHECK cycle.
- `rd_data` has zero latency.

Reset mid-game aborts immediately and returns all state to the reset values.

## Structure
- Shared package `tetris_pkg`: BOARD_W=10, BOARD_H=23, VISIBLE_H=20, state enum, coordinate widths.
- Sub-module `piece_cells`: centre → four cell coordinates.
- Sub-module `lowest_set_index`: 20-bit vector → 5-bit index.
- The FSM and the board datapath live in `tetris_engine`.

## Test plan
- Reset, then `start_game`=1 → state LOAD then DROP, with `piece_x`=4, `piece_y`=20, `rd_data`=0 for every row.
- 20 ticks → `piece_y`=0. Next tick → LOCK. Then row0=0x038, row1=0x010, state returns to DROP with y=20.
- From spawn, four `key_left` pulses → `piece_x` goes 3, 2, 1, 1 (wall blocks the last). Then nine `key_right` pulses → x ends at 8.
- In IDLE, write row0=0x3C7, then start and drop 21 ticks → after the clear, row0=0x010, row1=0, `lines_cleared`=1.
- In IDLE, write rows 19,20 with value 0x038 in row 20 → after start, LOAD detects collision → `game_over`=1, state OVER.
- Assert `resetn`=0 during DROP → all outputs return to the reset values asynchronously.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants, types and helpers for the Tetris game-logic core.
package tetris_pkg;

   localparam int BOARD_W   = 10;
   localparam int BOARD_H   = 23;
   localparam int VISIBLE_H = 20;
   localparam int X_W       = 4;
   localparam int Y_W       = 5;

   // Typed bounds so comparisons against coordinates stay width-matched.
   localparam logic [X_W-1:0] COL_LAST = 4'd9;
   localparam logic [Y_W-1:0] ROW_LAST = 5'd22;

   // Row k of the board is board[k]; bit j of a row is column j.
   typedef logic [BOARD_H-1:0][BOARD_W-1:0] board_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DROP  = 3'd2,
      ST_LOCK  = 3'd3,
      ST_CHECK = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   // Board occupancy lookup; coordinates off the board read as empty so
   // neighbour probes past an edge never index outside the array.
   function automatic logic cell_set(input board_t b,
                                     input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y);
      if (x <= COL_LAST && y <= ROW_LAST) begin
         return b[y][x];
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of the completed-row vector.
module lowest_set_index
   import tetris_pkg::*;
(
   input  logic [VISIBLE_H-1:0] vec,
   output logic [Y_W-1:0]       idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = VISIBLE_H - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = Y_W'(i);
         end
      end
   end

endmodule

// File: rtl/piece_cells.sv
// Expands the centre of the fixed T piece into its four cell coordinates.
module piece_cells
   import tetris_pkg::*;
(
   input  logic [X_W-1:0]       x,
   input  logic [Y_W-1:0]       y,
   output logic [3:0][X_W-1:0]  cell_x,
   output logic [3:0][Y_W-1:0]  cell_y
);

   // Cells: centre, left arm, right arm, stem above the centre.
   always_comb begin
      cell_x[0] = x;
      cell_y[0] = y;
      cell_x[1] = x - X_W'(1);
      cell_y[1] = y;
      cell_x[2] = x + X_W'(1);
      cell_y[2] = y;
      cell_x[3] = x;
      cell_y[3] = y + Y_W'(1);
   end

endmodule

// File: rtl/tetris_engine.sv
// Tetris game core: playfield, falling T piece, control FSM, line clearing.
// tick, key_left and key_right are single-cycle strobes sampled on the rising
// clock edge; there is no back-pressure, a strobe that cannot act is dropped.
module tetris_engine
   import tetris_pkg::*;
#(
   parameter int SPAWN_X = 4,
   parameter int SPAWN_Y = 20
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start_game,
   input  logic                 tick,
   input  logic                 key_left,
   input  logic                 key_right,
   input  logic                 dbg_we,
   input  logic [4:0]           dbg_row,
   input  logic [BOARD_W-1:0]   dbg_data,
   input  logic [4:0]           rd_row,
   output logic [BOARD_W-1:0]   rd_data,
   output logic [X_W-1:0]       piece_x,
   output logic [Y_W-1:0]       piece_y,
   output logic [2:0]           state,
   output logic                 game_over,
   output logic [7:0]           lines_cleared
);

   localparam logic [X_W-1:0] SPAWN_X_C = X_W'(SPAWN_X);
   localparam logic [Y_W-1:0] SPAWN_Y_C = Y_W'(SPAWN_Y);

   state_t              state_q, state_next;
   board_t              board_q;
   logic [X_W-1:0]      px_q;
   logic [Y_W-1:0]      py_q;
   logic [7:0]          lines_q;

   logic [3:0][X_W-1:0] cell_x, spawn_x;
   logic [3:0][Y_W-1:0] cell_y, spawn_y;
   logic                filled_under, filled_left, filled_right, spawn_blocked;
   logic [VISIBLE_H-1:0] completed;
   logic [Y_W-1:0]      clr_idx;
   logic                upper_occupied;
   logic                dbg_write;
   logic                do_spawn, do_fall, do_left, do_right, do_lock, do_clear;

   piece_cells u_piece_cells (
      .x      (px_q),
      .y      (py_q),
      .cell_x (cell_x),
      .cell_y (cell_y)
   );

   // Spawn footprint is constant; a separate expansion avoids depending on
   // wherever the previous piece was left when LOAD is entered.
   piece_cells u_spawn_cells (
      .x      (SPAWN_X_C),
      .y      (SPAWN_Y_C),
      .cell_x (spawn_x),
      .cell_y (spawn_y)
   );

   lowest_set_index u_lowest_set_index (
      .vec (completed),
      .idx (clr_idx)
   );

   // Collision probes around the current piece and at the spawn position.
   always_comb begin
      filled_under  = 1'b0;
      filled_left   = 1'b0;
      filled_right  = 1'b0;
      spawn_blocked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         filled_under  |= (cell_y[i] == '0) |
                          cell_set(board_q, cell_x[i], cell_y[i] - Y_W'(1));
         filled_left   |= (cell_x[i] == '0) |
                          cell_set(board_q, cell_x[i] - X_W'(1), cell_y[i]);
         filled_right  |= (cell_x[i] == COL_LAST) |
                          cell_set(board_q, cell_x[i] + X_W'(1), cell_y[i]);
         spawn_blocked |= cell_set(board_q, spawn_x[i], spawn_y[i]);
      end
   end

   // Full-row detection over the visible rows only.
   always_comb begin
      completed = '0;
      for (int k = 0; k < VISIBLE_H; k++) begin
         completed[k] = &board_q[k];
      end
   end

   assign upper_occupied = |board_q[BOARD_H-1:VISIBLE_H];
   assign dbg_write      = dbg_we && (state_q == ST_IDLE) && (dbg_row <= ROW_LAST);

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Next-state logic and one-hot datapath commands; DROP follows a strict
   // priority of lock, fall, left, right.
   always_comb begin
      state_next = state_q;
      do_spawn   = 1'b0;
      do_fall    = 1'b0;
      do_left    = 1'b0;
      do_right   = 1'b0;
      do_lock    = 1'b0;
      do_clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_game) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            do_spawn   = 1'b1;
            state_next = spawn_blocked ? ST_OVER : ST_DROP;
         end
         ST_DROP: begin
            if (tick && filled_under)              state_next = ST_LOCK;
            else if (tick)                         do_fall    = 1'b1;
            else if (key_left && !filled_left)     do_left    = 1'b1;
            else if (key_right && !filled_right)   do_right   = 1'b1;
         end
         ST_LOCK: begin
            do_lock    = 1'b1;
            state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (|completed)          do_clear   = 1'b1;
            else if (upper_occupied) state_next = ST_OVER;
            else                     state_next = ST_LOAD;
         end
         ST_OVER: begin
            state_next = ST_OVER;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Playfield: debug writes in IDLE, piece locking, and one-row clears.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         board_q <= '0;
      end else if (dbg_write) begin
         board_q[dbg_row] <= dbg_data;
      end else if (do_lock) begin
         for (int i = 0; i < 4; i++) begin
            if (cell_x[i] <= COL_LAST && cell_y[i] <= ROW_LAST) begin
               board_q[cell_y[i]][cell_x[i]] <= 1'b1;
            end
         end
      end else if (do_clear) begin
         for (int k = 0; k < BOARD_H - 1; k++) begin
            if (Y_W'(k) >= clr_idx) begin
               board_q[k] <= board_q[k+1];
            end
         end
         board_q[BOARD_H-1] <= '0;
      end
   end

   // Piece centre position.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         px_q <= SPAWN_X_C;
         py_q <= SPAWN_Y_C;
      end else if (do_spawn) begin
         px_q <= SPAWN_X_C;
         py_q <= SPAWN_Y_C;
      end else if (do_fall) begin
         py_q <= py_q - Y_W'(1);
      end else if (do_left) begin
         px_q <= px_q - X_W'(1);
      end else if (do_right) begin
         px_q <= px_q + X_W'(1);
      end
   end

   // Saturating cleared-line counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lines_q <= '0;
      end else if (do_clear && lines_q != 8'hFF) begin
         lines_q <= lines_q + 8'd1;
      end
   end

   assign rd_data       = (rd_row <= ROW_LAST) ? board_q[rd_row] : '0;
   assign piece_x       = px_q;
   assign piece_y       = py_q;
   assign state         = state_q;
   assign game_over     = (state_q == ST_OVER);
   assign lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_engine.sv
// Directed self-checking bench for tetris_engine.
module tb_tetris_engine;

   localparam int S_IDLE  = 0;
   localparam int S_LOAD  = 1;
   localparam int S_DROP  = 2;
   localparam int S_LOCK  = 3;
   localparam int S_CHECK = 4;
   localparam int S_OVER  = 5;

   logic       clock, resetn, start_game, tick, key_left, key_right, dbg_we;
   logic [4:0] dbg_row, rd_row;
   logic [9:0] dbg_data, rd_data;
   logic [3:0] piece_x;
   logic [4:0] piece_y;
   logic [2:0] state;
   logic       game_over;
   logic [7:0] lines_cleared;

   int n_tests;
   int n_fail;

   tetris_engine #(.SPAWN_X(4), .SPAWN_Y(20)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .start_game    (start_game),
      .tick          (tick),
      .key_left      (key_left),
      .key_right     (key_right),
      .dbg_we        (dbg_we),
      .dbg_row       (dbg_row),
      .dbg_data      (dbg_data),
      .rd_row        (rd_row),
      .rd_data       (rd_data),
      .piece_x       (piece_x),
      .piece_y       (piece_y),
      .state         (state),
      .game_over     (game_over),
      .lines_cleared (lines_cleared)
   );

   // Clock: long period leaves room for several row reads inside one cycle.
   initial begin
      clock = 1'b0;
      forever #50 clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic read_row(input logic [4:0] r, output logic [9:0] d);
      rd_row = r;
      #1;
      d = rd_data;
   endtask

   task automatic all_rows_or(output logic [9:0] acc);
      logic [9:0] d;
      acc = '0;
      for (int r = 0; r < 23; r++) begin
         read_row(5'(r), d);
         acc |= d;
      end
   endtask

   task automatic press(input logic l, input logic r, input logic t);
      key_left  = l;
      key_right = r;
      tick      = t;
      step();
      key_left  = 1'b0;
      key_right = 1'b0;
      tick      = 1'b0;
   endtask

   task automatic dbg_write(input logic [4:0] r, input logic [9:0] d);
      dbg_we   = 1'b1;
      dbg_row  = r;
      dbg_data = d;
      step();
      dbg_we   = 1'b0;
   endtask

   task automatic start_play();
      start_game = 1'b1;
      step();
      start_game = 1'b0;
   endtask

   task automatic do_reset();
      #5 resetn = 1'b0;
      #5;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      logic [9:0] d;
      int exp_l[4];
      exp_l = '{3, 2, 1, 1};
      n_tests = 0;
      n_fail  = 0;
      resetn = 1'b1; start_game = 1'b0; tick = 1'b0; key_left = 1'b0; key_right = 1'b0;
      dbg_we = 1'b0; dbg_row = '0; dbg_data = '0; rd_row = '0;

      // Reset state
      #2 resetn = 1'b0;
      #10;
      check_eq("rst_state", 32'(state), S_IDLE);
      check_eq("rst_x", 32'(piece_x), 4);
      check_eq("rst_y", 32'(piece_y), 20);
      check_eq("rst_over", 32'(game_over), 0);
      check_eq("rst_lines", 32'(lines_cleared), 0);
      @(negedge clock);
      resetn = 1'b1;

      // Start: IDLE -> LOAD -> DROP at spawn, empty board
      start_play();
      check_eq("start_load", 32'(state), S_LOAD);
      step();
      check_eq("start_drop", 32'(state), S_DROP);
      check_eq("spawn_x", 32'(piece_x), 4);
      check_eq("spawn_y", 32'(piece_y), 20);
      all_rows_or(d);
      check_eq("empty_board", 32'(d), 0);

      // Fall to the floor, then lock
      for (int i = 0; i < 20; i++) press(1'b0, 1'b0, 1'b1);
      check_eq("fall_y0", 32'(piece_y), 0);
      press(1'b0, 1'b0, 1'b1);
      check_eq("lock_state", 32'(state), S_LOCK);
      step();
      check_eq("check_state", 32'(state), S_CHECK);
      read_row(5'd0, d);
      check_eq("lock_row0", 32'(d), 32'h038);
      read_row(5'd1, d);
      check_eq("lock_row1", 32'(d), 32'h010);
      step();
      check_eq("reload_state", 32'(state), S_LOAD);
      step();
      check_eq("redrop_state", 32'(state), S_DROP);
      check_eq("redrop_y", 32'(piece_y), 20);

      // Left moves with wall block, then right moves with wall block
      for (int i = 0; i < 4; i++) begin
         press(1'b1, 1'b0, 1'b0);
         check_eq($sformatf("left_%0d", i), 32'(piece_x), 32'(exp_l[i]));
      end
      for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1'b0);
      check_eq("right_wall", 32'(piece_x), 8);

      // Left beats right; tick beats keys
      press(1'b1, 1'b1, 1'b0);
      check_eq("both_keys_x", 32'(piece_x), 7);
      press(1'b1, 1'b0, 1'b1);
      check_eq("tick_vs_key_y", 32'(piece_y), 19);
      check_eq("tick_vs_key_x", 32'(piece_x), 7);

      // Asynchronous reset in DROP
      #5 resetn = 1'b0;
      #1;
      check_eq("arst_state", 32'(state), S_IDLE);
      check_eq("arst_x", 32'(piece_x), 4);
      check_eq("arst_y", 32'(piece_y), 20);
      all_rows_or(d);
      check_eq("arst_board", 32'(d), 0);
      @(negedge clock);
      resetn = 1'b1;

      // Line clear: prefilled row 0 completed by the first piece
      dbg_write(5'd0, 10'h3C7);
      read_row(5'd0, d);
      check_eq("dbg_row0", 32'(d), 32'h3C7);
      start_play();
      step();
      for (int i = 0; i < 21; i++) press(1'b0, 1'b0, 1'b1);
      check_eq("clr_lock", 32'(state), S_LOCK);
      press(1'b1, 1'b0, 1'b0);
      check_eq("key_in_lock_x", 32'(piece_x), 4);
      read_row(5'd0, d);
      check_eq("full_row0", 32'(d), 32'h3FF);
      step();
      check_eq("clr_state", 32'(state), S_CHECK);
      read_row(5'd0, d);
      check_eq("clr_row0", 32'(d), 32'h010);
      read_row(5'd1, d);
      check_eq("clr_row1", 32'(d), 0);
      check_eq("clr_lines", 32'(lines_cleared), 1);
      step();
      check_eq("clr_reload", 32'(state), S_LOAD);

      // Spawn collision -> OVER
      do_reset();
      dbg_write(5'd19, 10'h038);
      dbg_write(5'd20, 10'h038);
      start_play();
      check_eq("over_load", 32'(state), S_LOAD);
      step();
      check_eq("over_state", 32'(state), S_OVER);
      check_eq("over_flag", 32'(game_over), 1);
      dbg_write(5'd5, 10'h3FF);
      read_row(5'd5, d);
      check_eq("over_dbg_ignored", 32'(d), 0);
      start_play();
      step();
      check_eq("over_hold", 32'(state), S_OVER);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
